// File: rtl/icache_front.sv
// Direct-mapped one-word-per-line instruction cache front end. A hit returns one cycle after the request.
// A miss holds inst_valid/inst_addr until inst_ready. rdy_in low freezes everything, and rob_clear aborts the outstanding miss.
module icache_front #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic        inst_valid,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_result,
  input  logic        inst_ready
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  accept_hit;
  logic                  accept_miss;
  logic                  do_fill;
  logic                  unused_addr_lsb;

  assign req_idx  = fetch_addr[INDEX_BITS+1:2];
  assign req_tag  = fetch_addr[31:INDEX_BITS+2];
  // inst_addr still holds the missing address, so it supplies the fill index and tag.
  assign fill_idx = inst_addr[INDEX_BITS+1:2];
  assign fill_tag = inst_addr[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_addr_lsb = ^{fetch_addr[1:0], inst_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    do_fill     = 1'b0;
    if (rob_clear) begin
      state_d = IDLE;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (fetch_valid) begin
            if (hit) begin
              accept_hit = 1'b1;
            end else begin
              accept_miss = 1'b1;
              state_d     = MISS;
            end
          end
        end
        MISS: begin
          if (inst_ready) begin
            do_fill = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q     <= '0;
      fetch_ready <= 1'b0;
      fetch_inst  <= '0;
      inst_valid  <= 1'b0;
      inst_addr   <= '0;
    end else if (rob_clear) begin
      fetch_ready <= 1'b0;
      inst_valid  <= 1'b0;
    end else if (rdy_in) begin
      fetch_ready <= accept_hit | do_fill;
      if (accept_hit) begin
        fetch_inst <= data_mem[req_idx];
      end
      if (accept_miss) begin
        inst_valid <= 1'b1;
        inst_addr  <= {fetch_addr[31:2], 2'b00};
      end
      if (do_fill) begin
        fetch_inst        <= inst_result;
        inst_valid        <= 1'b0;
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage is not reset; the valid bits alone qualify it.
  always_ff @(posedge clk_in) begin
    if (do_fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= inst_result;
    end
  end

endmodule

// File: tb/tb_icache_front.sv
// Directed bench for icache_front: cold miss, hit, conflict, flush, stall and async reset scenarios.
module tb_icache_front;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [31:0] inst_result;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;

  icache_front #(.INDEX_BITS(5)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .rob_clear   (rob_clear),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_inst  (fetch_inst),
    .inst_valid  (inst_valid),
    .inst_addr   (inst_addr),
    .inst_result (inst_result),
    .inst_ready  (inst_ready)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in      = 1'b0;
    rdy_in      = 1'b1;
    rob_clear   = 1'b0;
    fetch_valid = 1'b0;
    fetch_addr  = '0;
    inst_result = '0;
    inst_ready  = 1'b0;
    step();
    step();
    check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    check("rst_inst_valid",  {31'd0, inst_valid},  32'd0);
    check("rst_inst_addr",   inst_addr,            32'd0);
    check("rst_fetch_inst",  fetch_inst,           32'd0);
    rst_in = 1'b1;

    // Cold miss then fill.
    fetch_valid = 1'b1; fetch_addr = 32'h0000_1004;
    step();
    fetch_valid = 1'b0;
    check("cold_inst_valid",  {31'd0, inst_valid},  32'd1);
    check("cold_inst_addr",   inst_addr,            32'h0000_1004);
    check("cold_no_ready",    {31'd0, fetch_ready}, 32'd0);
    step();
    check("cold_hold_valid",  {31'd0, inst_valid},  32'd1);
    inst_ready = 1'b1; inst_result = 32'h0050_0093;
    step();
    inst_ready = 1'b0;
    check("cold_fill_ready",  {31'd0, fetch_ready}, 32'd1);
    check("cold_fill_inst",   fetch_inst,           32'h0050_0093);
    check("cold_fill_drop",   {31'd0, inst_valid},  32'd0);
    step();
    check("cold_pulse_end",   {31'd0, fetch_ready}, 32'd0);

    // Refetch hits; two back-to-back hits give one word per cycle.
    fetch_valid = 1'b1; fetch_addr = 32'h0000_1004;
    step();
    check("hit_ready",        {31'd0, fetch_ready}, 32'd1);
    check("hit_inst",         fetch_inst,           32'h0050_0093);
    check("hit_no_mem_req",   {31'd0, inst_valid},  32'd0);
    fetch_addr = 32'h0000_1006;
    step();
    fetch_valid = 1'b0;
    check("b2b_ready",        {31'd0, fetch_ready}, 32'd1);
    check("b2b_inst",         fetch_inst,           32'h0050_0093);
    step();
    check("b2b_end",          {31'd0, fetch_ready}, 32'd0);

    // inst_ready outside MISS is ignored.
    inst_ready = 1'b1; inst_result = 32'h1111_1111;
    step();
    inst_ready = 1'b0;
    check("idle_ready_ign",   {31'd0, fetch_ready}, 32'd0);

    // Conflict on index 1 with a different tag.
    fetch_valid = 1'b1; fetch_addr = 32'h0000_1084;
    step();
    fetch_valid = 1'b0;
    check("conf_miss",        {31'd0, inst_valid},  32'd1);
    check("conf_addr",        inst_addr,            32'h0000_1084);
    inst_ready = 1'b1; inst_result = 32'hDEAD_BEEF;
    step();
    inst_ready = 1'b0;
    check("conf_fill_inst",   fetch_inst,           32'hDEAD_BEEF);
    fetch_valid = 1'b1; fetch_addr = 32'h0000_1084;
    step();
    check("conf_hit",         {31'd0, fetch_ready}, 32'd1);
    check("conf_hit_inst",    fetch_inst,           32'hDEAD_BEEF);
    fetch_addr = 32'h0000_1004;
    step();
    fetch_valid = 1'b0;
    check("conf_evicted",     {31'd0, inst_valid},  32'd1);
    check("conf_evict_addr",  inst_addr,            32'h0000_1004);
    inst_ready = 1'b1; inst_result = 32'h0050_0093;
    step();
    inst_ready = 1'b0;
    check("conf_refill",      fetch_inst,           32'h0050_0093);

    // Flush coinciding with inst_ready; fetch requests in MISS and during the flush are ignored.
    fetch_valid = 1'b1; fetch_addr = 32'h0000_2000;
    step();
    check("flush_miss_addr",  inst_addr,            32'h0000_2000);
    fetch_addr = 32'h0000_3000;
    step();
    check("miss_ignores_req", inst_addr,            32'h0000_2000);
    rob_clear = 1'b1; inst_ready = 1'b1; inst_result = 32'hAAAA_5555;
    fetch_addr = 32'h0000_1004;
    step();
    rob_clear = 1'b0; inst_ready = 1'b0; fetch_valid = 1'b0;
    check("flush_no_ready",   {31'd0, fetch_ready}, 32'd0);
    check("flush_drop_req",   {31'd0, inst_valid},  32'd0);
    step();
    check("flush_stays_idle", {31'd0, fetch_ready}, 32'd0);
    fetch_valid = 1'b1; fetch_addr = 32'h0000_2000;
    step();
    fetch_valid = 1'b0;
    check("flush_no_fill",    {31'd0, inst_valid},  32'd1);
    inst_ready = 1'b1; inst_result = 32'h1234_5678;
    step();
    inst_ready = 1'b0;
    check("flush_refill",     fetch_inst,           32'h1234_5678);

    // rdy_in low for three cycles during MISS, with inst_ready pulsed while stalled.
    fetch_valid = 1'b1; fetch_addr = 32'h0000_3008;
    step();
    fetch_valid = 1'b0;
    check("stall_miss",       {31'd0, inst_valid},  32'd1);
    rdy_in = 1'b0;
    step();
    check("stall1_valid",     {31'd0, inst_valid},  32'd1);
    inst_ready = 1'b1; inst_result = 32'hFFFF_0000;
    step();
    inst_ready = 1'b0;
    check("stall2_valid",     {31'd0, inst_valid},  32'd1);
    check("stall2_no_ready",  {31'd0, fetch_ready}, 32'd0);
    step();
    check("stall3_addr",      inst_addr,            32'h0000_3008);
    rdy_in = 1'b1;
    step();
    check("stall_no_fill",    {31'd0, inst_valid},  32'd1);
    check("stall_no_ready",   {31'd0, fetch_ready}, 32'd0);
    inst_ready = 1'b1; inst_result = 32'h0BAD_F00D;
    step();
    inst_ready = 1'b0;
    check("stall_fill_rdy",   {31'd0, fetch_ready}, 32'd1);
    check("stall_fill_inst",  fetch_inst,           32'h0BAD_F00D);
    fetch_valid = 1'b1; fetch_addr = 32'h0000_3008;
    step();
    fetch_valid = 1'b0;
    check("stall_hit",        {31'd0, fetch_ready}, 32'd1);
    check("stall_hit_inst",   fetch_inst,           32'h0BAD_F00D);

    // Asynchronous reset in the middle of a MISS.
    fetch_valid = 1'b1; fetch_addr = 32'h0000_4000;
    step();
    fetch_valid = 1'b0;
    check("arst_miss",        {31'd0, inst_valid},  32'd1);
    #1 rst_in = 1'b0;
    #1;
    check("arst_async_drop",  {31'd0, inst_valid},  32'd0);
    check("arst_addr_clr",    inst_addr,            32'd0);
    step();
    rst_in = 1'b1;
    fetch_valid = 1'b1; fetch_addr = 32'h0000_1004;
    step();
    fetch_valid = 1'b0;
    check("arst_cold_miss",   {31'd0, inst_valid},  32'd1);
    check("arst_no_hit",      {31'd0, fetch_ready}, 32'd0);
    inst_ready = 1'b1; inst_result = 32'h0050_0093;
    step();
    inst_ready = 1'b0;
    check("arst_refill",      fetch_inst,           32'h0050_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
